// File: rtl/seq_unlock_pkg.sv
// Shared types and helpers for the seq_unlock key-sequence unlocker.
package seq_unlock_pkg;

  localparam int KEY_W_MAX = 64;

  typedef enum logic [1:0] {IDLE, COLLECT, OPEN, LOCKOUT} state_e;

  // Masked compare: bits with mask=0 are don't-care. Narrower keys are zero-extended.
  function automatic logic key_match(input logic [KEY_W_MAX-1:0] pat,
                                     input logic [KEY_W_MAX-1:0] msk,
                                     input logic [KEY_W_MAX-1:0] key);
    return ((key ^ pat) & msk) == '0;
  endfunction

endpackage

// File: rtl/seq_unlock_timer.sv
// Loadable down-counter shared by the inter-key timeout and the lockout hold.
module seq_unlock_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                       r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // Flags the edge on which the count steps down to zero, so the owner can act on it.
  assign o_zero = i_dec && (r_cnt == TW'(1));

endmodule

// File: rtl/seq_unlock.sv
// Multi-step masked key-sequence unlocker with inter-key timeout and relock.
// Optional failed-attempt lockout enabled by defining SEQ_UNLOCK_LOCKOUT_EN.
module seq_unlock
  import seq_unlock_pkg::*;
#(
  parameter int                     WIDTH          = 8,
  parameter int                     STEPS          = 4,
  parameter logic [STEPS*WIDTH-1:0] PATTERN        = '0,
  parameter logic [STEPS*WIDTH-1:0] MASK           = '1,
  parameter int                     TIMEOUT        = 16,
  parameter int                     MAX_FAILS      = 3,
  parameter int                     LOCKOUT_CYCLES = 32,
  localparam int                    SW             = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [WIDTH-1:0] key,
  input  logic             relock,
  output logic             unlock,
  output logic [SW-1:0]    step,
  output logic             fail,
  output logic             timeout,
  output logic             locked_out
);

  localparam int TMAX = (TIMEOUT > LOCKOUT_CYCLES) ? TIMEOUT : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  if (WIDTH < 1 || WIDTH > KEY_W_MAX) begin : g_bad_width
    $error("seq_unlock: WIDTH out of range");
  end
  if (STEPS < 1 || TIMEOUT < 1 || MAX_FAILS < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
    $error("seq_unlock: STEPS/TIMEOUT/MAX_FAILS/LOCKOUT_CYCLES must be >= 1");
  end

  state_e          r_state;
  logic [SW-1:0]   r_step;
  logic            r_unlock;
  logic            r_fail;
  logic            r_timeout;

  logic [WIDTH-1:0] w_pat, w_msk;
  logic             w_hit, w_last;
  logic             w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [TW-1:0]    w_tmr_val;

  assign w_pat  = PATTERN[int'(r_step)*WIDTH +: WIDTH];
  assign w_msk  = MASK[int'(r_step)*WIDTH +: WIDTH];
  assign w_hit  = key_match(KEY_W_MAX'(w_pat), KEY_W_MAX'(w_msk), KEY_W_MAX'(key));
  assign w_last = (int'(r_step) == STEPS - 1);

`ifdef SEQ_UNLOCK_LOCKOUT_EN
  localparam int FCW = $clog2(MAX_FAILS + 1);
  logic [FCW-1:0] r_fail_cnt;
  logic           r_locked_out;
  logic           w_fail_trip;
  assign w_fail_trip = (int'(r_fail_cnt) >= MAX_FAILS - 1);
  assign locked_out  = r_locked_out;
`else
  assign locked_out  = 1'b0;
`endif

  // Timer owner: reload on every accepted key, count down while waiting for the next one.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = TW'(TIMEOUT);
    w_tmr_dec  = 1'b0;
    case (r_state)
      IDLE, COLLECT: begin
        if (!relock) begin
          if (key_valid) begin
            if (w_hit) w_tmr_load = 1'b1;
`ifdef SEQ_UNLOCK_LOCKOUT_EN
            else if (w_fail_trip) begin
              w_tmr_load = 1'b1;
              w_tmr_val  = TW'(LOCKOUT_CYCLES);
            end
`endif
          end else begin
            w_tmr_dec = (r_state == COLLECT);
          end
        end
      end
`ifdef SEQ_UNLOCK_LOCKOUT_EN
      LOCKOUT: w_tmr_dec = 1'b1;
`endif
      default: ;
    endcase
  end

  seq_unlock_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_unlock  <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
`ifdef SEQ_UNLOCK_LOCKOUT_EN
      r_fail_cnt   <= '0;
      r_locked_out <= 1'b0;
`endif
    end else begin
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE, COLLECT: begin
          if (relock) begin
            r_state <= IDLE;
            r_step  <= '0;
          end else if (key_valid) begin
            if (w_hit) begin
              if (w_last) begin
                r_state  <= OPEN;
                r_step   <= '0;
                r_unlock <= 1'b1;
`ifdef SEQ_UNLOCK_LOCKOUT_EN
                r_fail_cnt <= '0;
`endif
              end else begin
                r_state <= COLLECT;
                r_step  <= r_step + 1'b1;
              end
            end else begin
              r_fail  <= 1'b1;
              r_step  <= '0;
              r_state <= IDLE;
`ifdef SEQ_UNLOCK_LOCKOUT_EN
              if (w_fail_trip) begin
                r_state      <= LOCKOUT;
                r_locked_out <= 1'b1;
                r_fail_cnt   <= FCW'(MAX_FAILS);
              end else begin
                r_fail_cnt   <= r_fail_cnt + 1'b1;
              end
`endif
            end
          end else if (r_state == COLLECT && w_tmr_zero) begin
            r_state   <= IDLE;
            r_step    <= '0;
            r_timeout <= 1'b1;
          end
        end
        OPEN: begin
          if (relock) begin
            r_state  <= IDLE;
            r_unlock <= 1'b0;
          end
        end
`ifdef SEQ_UNLOCK_LOCKOUT_EN
        LOCKOUT: begin
          if (w_tmr_zero) begin
            r_state      <= IDLE;
            r_locked_out <= 1'b0;
            r_fail_cnt   <= '0;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign unlock  = r_unlock;
  assign step    = r_step;
  assign fail    = r_fail;
  assign timeout = r_timeout;

endmodule

// File: doc/seq_unlock.md
# seq_unlock

Parametrised multi-step key-sequence unlocker: generalises a single-pattern wildcard key match into an ordered sequence of STEPS masked key matches. Adds inter-key timeout, explicit relock, and optional failed-attempt lockout. Sits in the sandbox examples as a deeper FSM target for formal and simulation exercises.

## Interface
- WIDTH, 8: key width in bits (>=1)
- STEPS, 4: number of keys in the sequence (>=1)
- PATTERN, '0: logic [STEPS*WIDTH-1:0]; step i expected value at bits [i*WIDTH +: WIDTH]
- MASK, '1: logic [STEPS*WIDTH-1:0]; 1 = bit compared, 0 = don't-care
- TIMEOUT, 16: max idle cycles between keys once a sequence has started (>=1)
- MAX_FAILS, 3: consecutive failures that trigger lockout (>=1; LOCKOUT_EN only)
- LOCKOUT_CYCLES, 32: lockout duration in cycles (>=1; LOCKOUT_EN only)
- clk  input  1  single clock; all logic on posedge clk
- rst  input  1  synchronous, active-high reset
- key_valid  input  1  key presented this cycle
- key  input  WIDTH  key value, sampled when key_valid=1
- relock  input  1  close the lock or abort an in-progress sequence
- unlock  output  1  lock open
- step  output  SW=max(1,$clog2(STEPS))  index of the next expected key
- fail  output  1  one-cycle pulse on mismatch
- timeout  output  1  one-cycle pulse on inter-key timeout
- locked_out  output  1  lockout active (0 without LOCKOUT_EN)

## Operation
- States: IDLE (step=0), COLLECT (0<step<STEPS), OPEN, LOCKOUT.
- Match: hit = ((key ^ PATTERN[step]) & MASK[step]) == 0.
- IDLE/COLLECT, key_valid & hit: if step==STEPS-1 -> OPEN, step<=0; else step++, state COLLECT. Timer reloaded to TIMEOUT.
- IDLE/COLLECT, key_valid & !hit: fail pulse, step<=0, -> IDLE; fail_cnt++. If fail_cnt reaches MAX_FAILS -> LOCKOUT instead.
- COLLECT, no key_valid: timer decrements; on reaching 0 -> IDLE, step<=0, timeout pulse. fail_cnt unchanged.
- OPEN: unlock=1; key_valid ignored; fail_cnt cleared on entry; relock -> IDLE.
- LOCKOUT: key_valid ignored (no fail pulses); after LOCKOUT_CYCLES cycles -> IDLE, fail_cnt<=0.
- relock in IDLE/COLLECT: -> IDLE, step<=0, no fail or timeout pulse. relock in LOCKOUT: ignored.
- STEPS==1: IDLE hit goes directly to OPEN; COLLECT is unreachable.

## Timing
- All outputs registered. Reset values: unlock=0, step=0, fail=0, timeout=0, locked_out=0; state IDLE, fail_cnt=0, timer=0.
- unlock rises the cycle after the final matching key is sampled; it falls the cycle after relock is sampled.
- fail and timeout are high for exactly one cycle, the cycle after the triggering event.
- locked_out rises together with the fail pulse of the MAX_FAILS-th failure. It stays high for exactly LOCKOUT_CYCLES cycles.
- Timeout: with the last accepted key at cycle t and no further key_valid, timeout is high at cycle t+TIMEOUT+1.
- Precedence: rst > relock > key_valid > timer expiry. A key arriving in the expiry cycle is evaluated normally.
- rst mid-sequence, in OPEN or in LOCKOUT: returns everything to reset values on the next edge.
- Counter widths: timer $clog2(max(TIMEOUT,LOCKOUT_CYCLES)+1); fail_cnt $clog2(MAX_FAILS+1). fail_cnt saturates and never wraps.

## Configuration
- SEQ_UNLOCK_LOCKOUT_EN defined: fail_cnt, the LOCKOUT state and locked_out are implemented as above.
- SEQ_UNLOCK_LOCKOUT_EN undefined: no fail counter and no LOCKOUT state; failures only reset to IDLE; locked_out tied 0; MAX_FAILS and LOCKOUT_CYCLES unused.

## Structure
- Package seq_unlock_pkg: state enum typedef (IDLE, COLLECT, OPEN, LOCKOUT); masked-match function taking pattern, mask and key.
- Sub-module seq_unlock_timer: loadable down-counter with a zero flag, shared by timeout and lockout. The two never run at the same time.
- Under FORMAL: the bench carries the properties. unlock implies the previous state was OPEN or the final step hit. fail and timeout are never high together. locked_out implies !unlock.

## Test plan
Configuration for all scenarios: WIDTH=8, STEPS=3, PATTERN={8'h3C,8'h84,8'hA5} (step2..0), MASK={8'hF0,8'hA5,8'hFF}, TIMEOUT=4, MAX_FAILS=2, LOCKOUT_CYCLES=5, LOCKOUT_EN defined.
- Keys A5, 86, 3F on consecutive cycles -> step goes 1,2,0; unlock=1 the cycle after 3F. relock -> unlock=0 the next cycle.
- Keys A5, then 8'h04 (bit 7 mismatch) -> fail pulse; step=0; unlock stays 0.
- Key A5, then idle -> timeout pulse exactly 5 cycles after the A5 sample; step=0; no fail pulse.
- Two mismatches (8'h00 twice) -> locked_out=1 for 5 cycles. A5, 84, 3C sent during lockout are ignored, with no fail pulses. After lockout the correct sequence unlocks.
- Key A5 with relock high in the same cycle -> step stays 0; no pulses.
- rst asserted after A5, 84 -> all outputs 0 next cycle. The following A5, 84, 3C unlocks normally.
